axi_master_traffic_gen: RTL

// Synthesizable, parametrised AXI4 master traffic generator and self-checker for FPGA bring-up of the interconnect.

---
 rtl/axi_master_traffic_gen.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_master_traffic_gen.sv
// AXI4 master traffic generator: issues AW/AR bursts, streams incrementing W data, checks B/R in order.
// Define TRAFFIC_THROTTLE_EN to gate W valid / R ready with a 16-bit LFSR against WR/RD_CAPACITY.
module axi_master_traffic_gen #(
    parameter int          ID_WIDTH    = 2,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          OUTSTD_LOG2 = 4,
    parameter int          CNT_WIDTH   = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                    MASTER_CLK,
    input  logic                    MASTER_RST,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic                    CMD_WRITE,
    input  logic [ID_WIDTH-1:0]     CMD_ID,
    input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
    input  logic [7:0]              CMD_LEN,
    input  logic [DATA_WIDTH-1:0]   CMD_DATA,
    input  logic [4:0]              WR_CAPACITY,
    input  logic [4:0]              RD_CAPACITY,
    output logic [ID_WIDTH-1:0]     MASTER_WR_ADDR_ID,
    output logic [ADDR_WIDTH-1:0]   MASTER_WR_ADDR,
    output logic [7:0]              MASTER_WR_ADDR_LEN,
    output logic [1:0]              MASTER_WR_ADDR_BURST,
    output logic                    MASTER_WR_ADDR_VALID,
    input  logic                    MASTER_WR_ADDR_READY,
    output logic [DATA_WIDTH-1:0]   MASTER_WR_DATA,
    output logic [DATA_WIDTH/8-1:0] MASTER_WR_STRB,
    output logic                    MASTER_WR_DATA_LAST,
    output logic                    MASTER_WR_DATA_VALID,
    input  logic                    MASTER_WR_DATA_READY,
    input  logic [ID_WIDTH-1:0]     MASTER_WR_BACK_ID,
    input  logic [1:0]              MASTER_WR_BACK_RESP,
    input  logic                    MASTER_WR_BACK_VALID,
    output logic                    MASTER_WR_BACK_READY,
    output logic [ID_WIDTH-1:0]     MASTER_RD_ADDR_ID,
    output logic [ADDR_WIDTH-1:0]   MASTER_RD_ADDR,
    output logic [7:0]              MASTER_RD_ADDR_LEN,
    output logic [1:0]              MASTER_RD_ADDR_BURST,
    output logic                    MASTER_RD_ADDR_VALID,
    input  logic                    MASTER_RD_ADDR_READY,
    input  logic [ID_WIDTH-1:0]     MASTER_RD_BACK_ID,
    input  logic [DATA_WIDTH-1:0]   MASTER_RD_DATA,
    input  logic [1:0]              MASTER_RD_DATA_RESP,
    input  logic                    MASTER_RD_DATA_LAST,
    input  logic                    MASTER_RD_DATA_VALID,
    output logic                    MASTER_RD_DATA_READY,
    output logic [CNT_WIDTH-1:0]    WR_DONE_CNT,
    output logic [CNT_WIDTH-1:0]    RD_DONE_CNT,
    output logic [CNT_WIDTH-1:0]    ERR_CNT,
    output logic                    ERR_FLAG,
    output logic                    IDLE
);
    localparam int DEPTH = 1 << OUTSTD_LOG2;
    localparam int PW    = OUTSTD_LOG2 + 1;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [7:0]            len;
        logic [DATA_WIDTH-1:0] data;
    } ent_t;
    typedef enum logic {W_IDLE, W_SEND} w_state_t;

    ent_t                  wr_mem [DEPTH];
    ent_t                  rd_mem [DEPTH];
    logic [PW-1:0]         wr_ptr, d_ptr, rsp_ptr, rd_wptr, rd_ptr;
    logic [DATA_WIDTH-1:0] aw_data, ar_data;
    logic [7:0]            w_beat, r_beat;
    w_state_t              w_state, w_state_nxt;
    ent_t                  w_head, b_head, r_head;
    logic wr_full, rd_full, cmd_acc, aw_hs, ar_hs, w_hs, w_last, w_more, thr_ok;
    logic b_empty, b_pop, b_err, r_hs, r_empty, r_err;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a, input logic [1:0] inc);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    assign wr_full   = (wr_ptr - rsp_ptr) == PW'(DEPTH);
    assign rd_full   = (rd_wptr - rd_ptr) == PW'(DEPTH);
    assign CMD_READY = !MASTER_WR_ADDR_VALID && !MASTER_RD_ADDR_VALID && !(CMD_WRITE ? wr_full : rd_full);
    assign cmd_acc   = CMD_VALID && CMD_READY;
    assign aw_hs     = MASTER_WR_ADDR_VALID && MASTER_WR_ADDR_READY;
    assign ar_hs     = MASTER_RD_ADDR_VALID && MASTER_RD_ADDR_READY;
    assign MASTER_WR_ADDR_BURST = 2'b01;
    assign MASTER_RD_ADDR_BURST = 2'b01;
    assign MASTER_WR_BACK_READY = 1'b1;
    assign IDLE = !MASTER_WR_ADDR_VALID && !MASTER_RD_ADDR_VALID && (wr_ptr == rsp_ptr) && (rd_ptr == rd_wptr);

    always_ff @(posedge MASTER_CLK) begin
        if (MASTER_RST) begin
            MASTER_WR_ADDR_VALID <= 1'b0;
            MASTER_RD_ADDR_VALID <= 1'b0;
        end else begin
            if (cmd_acc && CMD_WRITE)       MASTER_WR_ADDR_VALID <= 1'b1;
            else if (aw_hs)                 MASTER_WR_ADDR_VALID <= 1'b0;
            if (cmd_acc && !CMD_WRITE)      MASTER_RD_ADDR_VALID <= 1'b1;
            else if (ar_hs)                 MASTER_RD_ADDR_VALID <= 1'b0;
        end
    end

    // Address/payload registers and FIFO storage carry no reset; validity lives in the pointers.
    always_ff @(posedge MASTER_CLK) begin
        if (cmd_acc && CMD_WRITE) begin
            MASTER_WR_ADDR_ID  <= CMD_ID;
            MASTER_WR_ADDR     <= CMD_ADDR;
            MASTER_WR_ADDR_LEN <= CMD_LEN;
            aw_data            <= CMD_DATA;
        end
        if (cmd_acc && !CMD_WRITE) begin
            MASTER_RD_ADDR_ID  <= CMD_ID;
            MASTER_RD_ADDR     <= CMD_ADDR;
            MASTER_RD_ADDR_LEN <= CMD_LEN;
            ar_data            <= CMD_DATA;
        end
        if (aw_hs) wr_mem[wr_ptr[OUTSTD_LOG2-1:0]] <= '{MASTER_WR_ADDR_ID, MASTER_WR_ADDR_LEN, aw_data};
        if (ar_hs) rd_mem[rd_wptr[OUTSTD_LOG2-1:0]] <= '{MASTER_RD_ADDR_ID, MASTER_RD_ADDR_LEN, ar_data};
    end

    assign w_head = wr_mem[d_ptr[OUTSTD_LOG2-1:0]];
    assign w_hs   = (w_state == W_SEND) && MASTER_WR_DATA_READY;
    assign w_last = (w_beat == w_head.len);
    assign w_more = (w_hs && w_last) ? ((d_ptr + PW'(1)) != wr_ptr) : (d_ptr != wr_ptr);

    assign MASTER_WR_DATA       = w_head.data + DATA_WIDTH'(w_beat);
    assign MASTER_WR_STRB       = '1;
    assign MASTER_WR_DATA_LAST  = w_last;
    assign MASTER_WR_DATA_VALID = (w_state == W_SEND);

    // Throttle only gates raising VALID; a presented beat stays until accepted.
    always_comb begin
        w_state_nxt = w_state;
        if (w_state == W_IDLE || w_hs) w_state_nxt = (w_more && thr_ok) ? W_SEND : W_IDLE;
    end

    assign b_head  = wr_mem[rsp_ptr[OUTSTD_LOG2-1:0]];
    assign b_empty = (rsp_ptr == d_ptr);
    assign b_pop   = MASTER_WR_BACK_VALID && !b_empty;
    assign b_err   = MASTER_WR_BACK_VALID &&
                     (b_empty || MASTER_WR_BACK_ID != b_head.id || MASTER_WR_BACK_RESP != 2'b00);

    assign r_head  = rd_mem[rd_ptr[OUTSTD_LOG2-1:0]];
    assign r_hs    = MASTER_RD_DATA_VALID && MASTER_RD_DATA_READY;
    assign r_empty = (rd_ptr == rd_wptr);
    assign r_err   = r_hs && (r_empty || MASTER_RD_BACK_ID != r_head.id ||
                     MASTER_RD_DATA != r_head.data + DATA_WIDTH'(r_beat) || MASTER_RD_DATA_RESP != 2'b00 ||
                     MASTER_RD_DATA_LAST != (r_beat == r_head.len));

    always_ff @(posedge MASTER_CLK) begin
        if (MASTER_RST) begin
            w_state     <= W_IDLE;
            wr_ptr      <= '0;
            d_ptr       <= '0;
            rsp_ptr     <= '0;
            rd_wptr     <= '0;
            rd_ptr      <= '0;
            w_beat      <= '0;
            r_beat      <= '0;
            WR_DONE_CNT <= '0;
            RD_DONE_CNT <= '0;
            ERR_CNT     <= '0;
            ERR_FLAG    <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) wr_ptr  <= wr_ptr + PW'(1);
            if (ar_hs) rd_wptr <= rd_wptr + PW'(1);
            if (w_hs) begin
                if (w_last) begin
                    d_ptr  <= d_ptr + PW'(1);
                    w_beat <= '0;
                end else begin
                    w_beat <= w_beat + 8'd1;
                end
            end
            if (b_pop) rsp_ptr <= rsp_ptr + PW'(1);
            if (r_hs && !r_empty) begin
                if (MASTER_RD_DATA_LAST) begin
                    rd_ptr <= rd_ptr + PW'(1);
                    r_beat <= '0;
                end else begin
                    r_beat <= r_beat + 8'd1;
                end
            end
            WR_DONE_CNT <= sat_add(WR_DONE_CNT, {1'b0, b_pop});
            RD_DONE_CNT <= sat_add(RD_DONE_CNT, {1'b0, r_hs && !r_empty && MASTER_RD_DATA_LAST});
            ERR_CNT     <= sat_add(ERR_CNT, {1'b0, b_err} + {1'b0, r_err});
            ERR_FLAG    <= ERR_FLAG | b_err | r_err;
        end
    end

`ifdef TRAFFIC_THROTTLE_EN
    logic [15:0] lfsr;
    always_ff @(posedge MASTER_CLK) begin
        if (MASTER_RST) begin
            lfsr                 <= LFSR_SEED;
            MASTER_RD_DATA_READY <= 1'b0;
        end else begin
            lfsr                 <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            MASTER_RD_DATA_READY <= (lfsr[9:5] < RD_CAPACITY) || (RD_CAPACITY == 5'd31);
        end
    end
    assign thr_ok = (lfsr[4:0] < WR_CAPACITY) || (WR_CAPACITY == 5'd31);
`else
    logic unused_cfg;
    assign unused_cfg = ^{WR_CAPACITY, RD_CAPACITY, LFSR_SEED};
    assign thr_ok     = 1'b1;
    always_ff @(posedge MASTER_CLK) begin
        if (MASTER_RST) MASTER_RD_DATA_READY <= 1'b0;
        else            MASTER_RD_DATA_READY <= 1'b1;
    end
`endif
endmodule
